// File: rtl/hash_score_arbiter.sv
// Round-robin arbiter that shares one bits-off counter among several hash
// cores and keeps the best (lowest) bits-off score with its nonce and core.
module hash_score_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned HASH_W    = 1024,
  parameter int unsigned NONCE_W   = 64,
  parameter int unsigned COUNT_W   = 11,
  parameter int unsigned CORE_W    = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CORES-1:0]         req_i,
  input  logic [NUM_CORES*HASH_W-1:0]  hash_i,
  input  logic [NUM_CORES*NONCE_W-1:0] nonce_i,
  output logic [NUM_CORES-1:0]         grant_o,
  output logic [HASH_W-1:0]            bo_hash_o,
  output logic                         bo_new_hash_ready_o,
  input  logic                         bo_done_i,
  input  logic [COUNT_W-1:0]           bo_count_i,
  input  logic                         clear_best_i,
  output logic                         busy_o,
  output logic                         result_valid_o,
  output logic                         result_improved_o,
  output logic                         best_valid_o,
  output logic [COUNT_W-1:0]           best_count_o,
  output logic [NONCE_W-1:0]           best_nonce_o,
  output logic [CORE_W-1:0]            best_core_o
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StCompare} state_e;

  state_e              state_q;
  logic [CORE_W-1:0]   last_q;
  logic [HASH_W-1:0]   bo_hash_q;
  logic [NONCE_W-1:0]  nonce_q;
  logic [CORE_W-1:0]   core_q;
  logic [COUNT_W-1:0]  count_q;
  logic                best_valid_q;
  logic [COUNT_W-1:0]  best_count_q;
  logic [NONCE_W-1:0]  best_nonce_q;
  logic [CORE_W-1:0]   best_core_q;

  logic [CORE_W-1:0]   sel;
  logic                any_req;
  logic                eff_valid;
  logic                improved;

  // Round-robin pick: first requester searching upward from last grant + 1.
  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      int unsigned idx;
      idx = (int'(last_q) + 1 + i) % NUM_CORES;
      if (!any_req && req_i[idx]) begin
        any_req = 1'b1;
        sel     = CORE_W'(idx);
      end
    end
  end

  // Grant pulse is combinational so the hash is captured in the same cycle.
  always_comb begin
    grant_o = '0;
    if (state_q == StIdle && any_req && !rst_i) begin
      grant_o[sel] = 1'b1;
    end
  end

  // A clear arriving in the compare cycle forces the current result to win.
  always_comb begin
    eff_valid = best_valid_q && !clear_best_i;
    improved  = !eff_valid || (count_q < best_count_q);
  end

  // Control FSM plus capture and best-score registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      last_q       <= CORE_W'(NUM_CORES - 1);
      bo_hash_q    <= '0;
      nonce_q      <= '0;
      core_q       <= '0;
      count_q      <= '0;
      best_valid_q <= 1'b0;
      best_count_q <= '0;
      best_nonce_q <= '0;
      best_core_q  <= '0;
    end else begin
      if (clear_best_i) begin
        best_valid_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (any_req) begin
            bo_hash_q <= hash_i[int'(sel)*HASH_W +: HASH_W];
            nonce_q   <= nonce_i[int'(sel)*NONCE_W +: NONCE_W];
            core_q    <= sel;
            last_q    <= sel;
            state_q   <= StLaunch;
          end
        end
        StLaunch: state_q <= StWait;
        StWait: begin
          if (bo_done_i) begin
            count_q <= bo_count_i;
            state_q <= StCompare;
          end
        end
        StCompare: begin
          if (improved) begin
            best_valid_q <= 1'b1;
            best_count_q <= count_q;
            best_nonce_q <= nonce_q;
            best_core_q  <= core_q;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bo_hash_o           = bo_hash_q;
  assign bo_new_hash_ready_o = (state_q == StLaunch);
  assign busy_o              = (state_q != StIdle);
  assign result_valid_o      = (state_q == StCompare);
  assign result_improved_o   = (state_q == StCompare) && improved;
  assign best_valid_o        = best_valid_q;
  assign best_count_o        = best_count_q;
  assign best_nonce_o        = best_nonce_q;
  assign best_core_o         = best_core_q;

endmodule

// File: tb/tb_hash_score_arbiter.sv
// Directed bench for hash_score_arbiter; the bench acts as the bits-off unit.
module tb_hash_score_arbiter;

  localparam int N  = 4;
  localparam int HW = 1024;
  localparam int NW = 64;
  localparam int CW = 11;
  localparam int KW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*HW-1:0] hash = '0;
  logic [N*NW-1:0] nonce = '0;
  logic [N-1:0]    grant;
  logic [HW-1:0]   bo_hash;
  logic            bo_start;
  logic            bo_done = 1'b0;
  logic [CW-1:0]   bo_count = '0;
  logic            clear = 1'b0;
  logic            busy;
  logic            res_valid;
  logic            res_imp;
  logic            best_valid;
  logic [CW-1:0]   best_count;
  logic [NW-1:0]   best_nonce;
  logic [KW-1:0]   best_core;

  int errors = 0;
  int checks = 0;
  int cnt_tab [N];

  hash_score_arbiter #(
    .NUM_CORES(N), .HASH_W(HW), .NONCE_W(NW), .COUNT_W(CW), .CORE_W(KW)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .req_i              (req),
    .hash_i             (hash),
    .nonce_i            (nonce),
    .grant_o            (grant),
    .bo_hash_o          (bo_hash),
    .bo_new_hash_ready_o(bo_start),
    .bo_done_i          (bo_done),
    .bo_count_i         (bo_count),
    .clear_best_i       (clear),
    .busy_o             (busy),
    .result_valid_o     (res_valid),
    .result_improved_o  (res_imp),
    .best_valid_o       (best_valid),
    .best_count_o       (best_count),
    .best_nonce_o       (best_nonce),
    .best_core_o        (best_core)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] ones(input int n);
    logic [HW-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NW-1:0] nonce_of(input int k);
    return {32'hC0DE_0000, 32'(k * 17 + 1)};
  endfunction

  task automatic apply_hashes();
    for (int k = 0; k < N; k++) begin
      hash[k*HW +: HW]  = ones(cnt_tab[k]);
      nonce[k*NW +: NW] = nonce_of(k);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Grant in IDLE, then the start pulse; returns one step into WAIT.
  task automatic txn_start(input logic [N-1:0] r, input int core, input bit stray);
    req = r;
    #1;
    chk("grant", 64'(grant), 64'(1) << core);
    @(posedge clk); #1;
    req = '0;
    if (stray) bo_done = 1'b1;
    chk("start", 64'(bo_start), 1);
    chk("grant_pulse", 64'(grant), 0);
    chk("bo_hash", 64'(bo_hash == ones(cnt_tab[core])), 1);
    @(posedge clk); #1;
    bo_done = 1'b0;
    chk("start_pulse", 64'(bo_start), 0);
    if (stray) chk("stray_launch", 64'(res_valid), 0);
  endtask

  // Bits-off model: count ones of the captured hash after lat WAIT cycles.
  task automatic txn_finish(input int lat, input bit clr, input bit imp,
                            input int bcnt, input int bcore);
    repeat (lat - 1) begin @(posedge clk); #1; end
    chk("waiting", 64'(busy), 1);
    chk("wait_no_result", 64'(res_valid), 0);
    bo_count = CW'($countones(bo_hash));
    bo_done  = 1'b1;
    @(posedge clk); #1;
    bo_done  = 1'b0;
    bo_count = '0;
    if (clr) clear = 1'b1;
    #1;
    chk("result_valid", 64'(res_valid), 1);
    chk("improved", 64'(res_imp), 64'(imp));
    @(posedge clk); #1;
    clear = 1'b0;
    chk("result_pulse", 64'(res_valid), 0);
    chk("idle", 64'(busy), 0);
    chk("best_valid", 64'(best_valid), 1);
    chk("best_count", 64'(best_count), 64'(bcnt));
    chk("best_core", 64'(best_core), 64'(bcore));
    chk("best_nonce", best_nonce, nonce_of(bcore));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_best_valid", 64'(best_valid), 0);
    chk("rst_bo_hash", 64'(|bo_hash), 0);
    chk("rst_grant", 64'(grant), 0);
    rst = 1'b0;

    // Single request, 37 bits off, 10-cycle bits-off latency.
    cnt_tab = '{37, 5, 6, 7};
    apply_hashes();
    @(posedge clk); #1;
    txn_start(4'b0001, 0, 1'b0);
    txn_finish(10, 1'b0, 1'b1, 37, 0);

    // Round-robin with all requesting: 0,1,2,3,0,1; then core 1 drops: 2,3,0.
    do_reset();
    cnt_tab = '{10, 11, 12, 13};
    apply_hashes();
    txn_start(4'b1111, 0, 1'b0); txn_finish(1, 1'b0, 1'b1, 10, 0);
    txn_start(4'b1111, 1, 1'b0); txn_finish(1, 1'b0, 1'b0, 10, 0);
    txn_start(4'b1111, 2, 1'b0); txn_finish(1, 1'b0, 1'b0, 10, 0);
    txn_start(4'b1111, 3, 1'b0); txn_finish(1, 1'b0, 1'b0, 10, 0);
    txn_start(4'b1111, 0, 1'b0); txn_finish(1, 1'b0, 1'b0, 10, 0);
    txn_start(4'b1111, 1, 1'b0); txn_finish(1, 1'b0, 1'b0, 10, 0);
    txn_start(4'b1101, 2, 1'b0); txn_finish(1, 1'b0, 1'b0, 10, 0);
    txn_start(4'b1101, 3, 1'b0); txn_finish(1, 1'b0, 1'b0, 10, 0);
    txn_start(4'b1101, 0, 1'b0); txn_finish(1, 1'b0, 1'b0, 10, 0);

    // Scoring: 40, 35, 35 (tie keeps earlier), 50 from cores 1, 2, 3, 0.
    do_reset();
    cnt_tab = '{50, 40, 35, 35};
    apply_hashes();
    txn_start(4'b0010, 1, 1'b0); txn_finish(2, 1'b0, 1'b1, 40, 1);
    txn_start(4'b0100, 2, 1'b0); txn_finish(3, 1'b0, 1'b1, 35, 2);
    txn_start(4'b1000, 3, 1'b0); txn_finish(2, 1'b0, 1'b0, 35, 2);
    txn_start(4'b0001, 0, 1'b0); txn_finish(4, 1'b0, 1'b0, 35, 2);

    // Clear race: best 20, then clear during compare of a count-90 result.
    cnt_tab = '{20, 90, 1024, 0};
    apply_hashes();
    txn_start(4'b0001, 0, 1'b0); txn_finish(2, 1'b0, 1'b1, 20, 0);
    txn_start(4'b0010, 1, 1'b0); txn_finish(2, 1'b1, 1'b1, 90, 1);

    // Clear in IDLE drops valid but leaves the stored count stale.
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_valid", 64'(best_valid), 0);
    chk("clear_stale", 64'(best_count), 90);

    // Worst case HASH_W with no best held, then an exact match of 0.
    txn_start(4'b0100, 2, 1'b0); txn_finish(2, 1'b0, 1'b1, 1024, 2);
    txn_start(4'b1000, 3, 1'b0); txn_finish(2, 1'b0, 1'b1, 0, 3);

    // Asynchronous reset mid-WAIT, then a stray done in IDLE.
    do_reset();
    cnt_tab = '{60, 70, 80, 90};
    apply_hashes();
    txn_start(4'b0010, 1, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 0);
    chk("arst_bo_hash", 64'(|bo_hash), 0);
    chk("arst_best_valid", 64'(best_valid), 0);
    chk("arst_best_nonce", best_nonce, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bo_done = 1'b1;
    #1;
    chk("arst_done_idle", 64'(res_valid), 0);
    @(posedge clk); #1;
    bo_done = 1'b0;
    chk("arst_no_result", 64'(res_valid), 0);
    chk("arst_idle", 64'(busy), 0);
    txn_start(4'b1111, 0, 1'b0); txn_finish(2, 1'b0, 1'b1, 60, 0);

    // Stray done in IDLE and in LAUNCH; WAIT still exits on the real done.
    bo_done = 1'b1;
    @(posedge clk); #1;
    bo_done = 1'b0;
    chk("stray_idle_busy", 64'(busy), 0);
    chk("stray_idle_result", 64'(res_valid), 0);
    txn_start(4'b0100, 2, 1'b1);
    txn_finish(3, 1'b0, 1'b0, 60, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
